// File: rtl/router_pkg.sv
// router_pkg: shared FSM states, address/length field widths and FIFO flag position for router_1xn.
// Build option: ROUTER_PARITY_EN adds the parity states LOAD_PARITY and CHECK_PARITY.
package router_pkg;

    typedef enum logic [3:0] {
        DECODE,
        WAIT_EMPTY,
        LOAD_FIRST,
        LOAD_DATA,
        FIFO_FULL,
        LOAD_AFTER_FULL,
        DROP
`ifdef ROUTER_PARITY_EN
        , LOAD_PARITY,
        CHECK_PARITY
`endif
    } state_t;

    // The first-byte flag occupies the LSB of each FIFO entry; the data byte sits above it.
    localparam int FLAG_BIT = 0;

    function automatic int addr_w(input int n_ports);
        return (n_ports > 1) ? $clog2(n_ports) : 1;
    endfunction

    function automatic int len_w(input int data_w, input int n_ports);
        return data_w - addr_w(n_ports);
    endfunction

endpackage

// File: rtl/router_fifo_n.sv
// router_fifo_n: W-bit x DEPTH synchronous FIFO with flush and a registered, hold-on-idle read port.
module router_fifo_n #(
    parameter int W     = 9,
    parameter int DEPTH = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         we,
    input  logic [W-1:0] wdata,
    input  logic         re,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [PW:0]   r_cnt;
    logic          w_wr;
    logic          w_rd;

    assign empty = (r_cnt == '0);
    assign full  = (r_cnt == (PW+1)'(DEPTH));
    assign w_wr  = we && !full && !flush;
    assign w_rd  = re && !empty && !flush;

    // Pointers wrap naturally because DEPTH is a power of two; flush empties the queue in one edge.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + PW'(1);
            if (w_rd) r_rp <= r_rp + PW'(1);
            r_cnt <= r_cnt + (PW+1)'(w_wr) - (PW+1)'(w_rd);
        end
    end

    // Storage array, written only when there is room.
    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wp] <= wdata;
    end

    // Read data updates only on an accepted read and otherwise holds its last value.
    always_ff @(posedge clock) begin
        if (reset) rdata <= '0;
        else if (w_rd) rdata <= r_mem[r_rp];
    end

endmodule

// File: rtl/router_1xn.sv
// router_1xn: one-input, N-output packet router with per-port FIFOs and idle-timeout flush.
// Build option: define ROUTER_PARITY_EN for packets that end in a parity byte checked against the XOR of header and payload.
module router_1xn
    import router_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int N_PORTS    = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      pkt_valid,
    output logic                      busy,
    output logic                      err,
    input  logic [N_PORTS-1:0]        read_enb,
    output logic [N_PORTS*DATA_W-1:0] data_out,
    output logic [N_PORTS-1:0]        vld_out
);
    localparam int AW = addr_w(N_PORTS);
    localparam int TW = $clog2(TIMEOUT + 1);
`ifdef ROUTER_PARITY_EN
    localparam state_t S_END = LOAD_PARITY;
`else
    localparam state_t S_END = DECODE;
`endif

    state_t            r_state;
    state_t            w_next;
    logic [AW-1:0]     r_addr;
    logic [DATA_W-1:0] r_hdr;
    logic [DATA_W-1:0] r_hold;
`ifdef ROUTER_PARITY_EN
    logic [DATA_W-1:0] r_par;
    logic [DATA_W-1:0] r_rx_par;
`endif
    logic [AW-1:0]     w_hdr_addr;
    logic              w_hdr_ok;
    logic              w_load_st;
    logic              w_abort;
    logic              w_wr;
    logic              w_first;
    logic [DATA_W-1:0] w_wbyte;
    logic [DATA_W:0]   w_wdata;
    logic [N_PORTS-1:0] w_we;
    logic [N_PORTS-1:0] w_empty;
    logic [N_PORTS-1:0] w_full;
    logic [N_PORTS-1:0] w_flush;
    logic [N_PORTS-1:0] w_unused_flags;
    logic [DATA_W:0]   w_rdata [N_PORTS];

    assign w_hdr_addr = data_in[AW-1:0];
    assign w_hdr_ok   = 32'(w_hdr_addr) < 32'(N_PORTS);
    assign w_wdata    = {w_wbyte, w_first};
    assign vld_out    = ~w_empty;
`ifdef ROUTER_PARITY_EN
    assign w_load_st  = r_state inside {LOAD_FIRST, LOAD_DATA, FIFO_FULL, LOAD_AFTER_FULL, LOAD_PARITY};
`else
    assign w_load_st  = r_state inside {LOAD_FIRST, LOAD_DATA, FIFO_FULL, LOAD_AFTER_FULL};
`endif
    assign w_abort    = w_load_st && w_flush[r_addr];

    // Next state, busy, err and the FIFO write request; a timeout flush of the target port aborts the packet.
    always_comb begin
        w_next  = r_state;
        w_wr    = 1'b0;
        w_first = 1'b0;
        w_wbyte = data_in;
        busy    = 1'b0;
        err     = 1'b0;
        case (r_state)
            DECODE:
                if (pkt_valid) w_next = !w_hdr_ok ? DROP : w_empty[w_hdr_addr] ? LOAD_FIRST : WAIT_EMPTY;
            WAIT_EMPTY: begin
                busy = 1'b1;
                if (w_empty[r_addr]) w_next = LOAD_FIRST;
            end
            LOAD_FIRST: begin
                busy    = 1'b1;
                w_wr    = 1'b1;
                w_first = 1'b1;
                w_wbyte = r_hdr;
                w_next  = LOAD_DATA;
            end
            LOAD_DATA:
                if (!pkt_valid) w_next = S_END;
                else if (w_full[r_addr]) w_next = FIFO_FULL;
                else w_wr = 1'b1;
            FIFO_FULL: begin
                busy = 1'b1;
                if (!w_full[r_addr]) w_next = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                busy    = 1'b1;
                w_wr    = 1'b1;
                w_wbyte = r_hold;
                w_next  = pkt_valid ? LOAD_DATA : S_END;
            end
`ifdef ROUTER_PARITY_EN
            LOAD_PARITY: begin
                busy    = 1'b1;
                w_wbyte = r_rx_par;
                if (!w_full[r_addr]) begin
                    w_wr   = 1'b1;
                    w_next = CHECK_PARITY;
                end
            end
            CHECK_PARITY: begin
                busy   = 1'b1;
                err    = (r_par != r_rx_par);
                w_next = DECODE;
            end
`endif
            DROP:
                if (!pkt_valid) begin
                    err    = 1'b1;
                    w_next = DECODE;
                end
            default: w_next = DECODE;
        endcase
        if (w_abort) begin
            w_next = DECODE;
            w_wr   = 1'b0;
        end
    end

    // State register plus the header, overflow byte and parity latches.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= DECODE;
            r_addr   <= '0;
            r_hdr    <= '0;
            r_hold   <= '0;
`ifdef ROUTER_PARITY_EN
            r_par    <= '0;
            r_rx_par <= '0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == DECODE && pkt_valid) begin
                r_hdr  <= data_in;
                r_addr <= w_hdr_addr;
            end
            if (r_state == LOAD_DATA && pkt_valid) r_hold <= data_in;
`ifdef ROUTER_PARITY_EN
            if (r_state == DECODE && pkt_valid) r_par <= data_in;
            if (r_state == LOAD_DATA && pkt_valid) r_par <= r_par ^ data_in;
            if ((r_state == LOAD_DATA || r_state == LOAD_AFTER_FULL) && !pkt_valid) r_rx_par <= data_in;
`endif
        end
    end

    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        logic [TW-1:0] r_tmr;

        assign w_we[i]    = w_wr && (r_addr == AW'(i));
        assign w_flush[i] = vld_out[i] && !read_enb[i] && (r_tmr == TW'(TIMEOUT - 1));
        assign data_out[i*DATA_W +: DATA_W] = w_rdata[i][DATA_W:FLAG_BIT+1];
        assign w_unused_flags[i] = w_rdata[i][FLAG_BIT];

        // Counts consecutive unread cycles while the FIFO holds data; any read or an empty FIFO restarts it.
        always_ff @(posedge clock) begin
            r_tmr <= (reset || !vld_out[i] || read_enb[i]) ? '0 : r_tmr + TW'(1);
        end

        router_fifo_n #(
            .W    (DATA_W + 1),
            .DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clock(clock),
            .reset(reset),
            .flush(w_flush[i]),
            .we   (w_we[i]),
            .wdata(w_wdata),
            .re   (read_enb[i]),
            .rdata(w_rdata[i]),
            .empty(w_empty[i]),
            .full (w_full[i])
        );
    end

endmodule

// File: tb/tb_router_1xn.sv
// tb_router_1xn: scoreboard bench for router_1xn; u_dut uses defaults, u_small uses FIFO_DEPTH=4.
module tb_router_1xn;
`ifdef ROUTER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic        pv [2];
    logic [2:0]  rd [2];
    logic        busy_v [2];
    logic        err_v [2];
    logic [2:0]  vld_v [2];
    logic [23:0] dout_v [2];
    logic [2:0]  pend [2];
    logic [7:0]  exp_q [6][$];
    int          errs [2];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;

    router_1xn u_dut (
        .clock(clock), .reset(reset), .data_in(data_in), .pkt_valid(pv[0]), .busy(busy_v[0]),
        .err(err_v[0]), .read_enb(rd[0]), .data_out(dout_v[0]), .vld_out(vld_v[0])
    );

    router_1xn #(.FIFO_DEPTH(4)) u_small (
        .clock(clock), .reset(reset), .data_in(data_in), .pkt_valid(pv[1]), .busy(busy_v[1]),
        .err(err_v[1]), .read_enb(rd[1]), .data_out(dout_v[1]), .vld_out(vld_v[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: a read accepted at an edge is compared against the scoreboard after that edge.
    initial begin
        pend[0] = '0;
        pend[1] = '0;
        errs[0] = 0;
        errs[1] = 0;
        forever begin
            @(negedge clock);
            #1;
            for (int s = 0; s < 2; s++) begin
                for (int p = 0; p < 3; p++) begin
                    if (pend[s][p]) begin
                        if (exp_q[s*3+p].size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL unexpected_read dut%0d port%0d: got 0x%0h expected no data", s, p, dout_v[s][p*8 +: 8]);
                        end else begin
                            chk($sformatf("sb_dut%0d_port%0d", s, p), 32'(dout_v[s][p*8 +: 8]), 32'(exp_q[s*3+p].pop_front()));
                        end
                    end
                end
                pend[s] = reset ? 3'b000 : (rd[s] & vld_v[s]);
                if (err_v[s]) errs[s]++;
            end
        end
    end

    task automatic put(input int s, input logic [7:0] b, input logic v);
        int k = 0;
        data_in = b;
        pv[s] = v;
        while (busy_v[s] && k < 200) begin
            @(negedge clock);
            k++;
        end
        if (busy_v[s]) begin
            n_chk++;
            n_fail++;
            $display("FAIL put_timeout dut%0d: busy got 1 expected 0", s);
        end
        @(negedge clock);
    endtask

    task automatic send_pkt(input int s, input logic [7:0] hdr, input logic [63:0] pl, input int n,
                            input logic [7:0] bad, input bit push);
        logic [7:0] par;
        logic [7:0] b;
        bit keep;
        keep = push && (hdr[1:0] < 2'd3);
        par = hdr ^ bad;
        if (keep) exp_q[s*3 + int'(hdr[1:0])].push_back(hdr);
        put(s, hdr, 1'b1);
        for (int k = 0; k < n; k++) begin
            b = pl[8*k +: 8];
            par = par ^ b;
            if (keep) exp_q[s*3 + int'(hdr[1:0])].push_back(b);
            put(s, b, 1'b1);
        end
`ifdef ROUTER_PARITY_EN
        if (keep) exp_q[s*3 + int'(hdr[1:0])].push_back(par);
        put(s, par, 1'b0);
`endif
        put(s, 8'h00, 1'b0);
    endtask

    task automatic drain(input int s, input int p, input int n);
        int got = 0;
        for (int k = 0; k < 400 && got < n; k++) begin
            rd[s][p] = vld_v[s][p];
            if (vld_v[s][p]) got++;
            @(negedge clock);
        end
        rd[s][p] = 1'b0;
        @(negedge clock);
        chk($sformatf("drain_count_dut%0d_port%0d", s, p), got, n);
    endtask

    task automatic chk_idle(input int s, input string tag);
        chk({tag, "_busy"}, 32'(busy_v[s]), 0);
        chk({tag, "_err"}, 32'(err_v[s]), 0);
        chk({tag, "_vld"}, 32'(vld_v[s]), 0);
        chk({tag, "_dout"}, 32'(dout_v[s]), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end

    initial begin
        int e0;
        int e1;
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        rd[0] = '0;
        rd[1] = '0;
        repeat (3) @(negedge clock);
        chk_idle(0, "reset_dut0");
        chk_idle(1, "reset_dut1");
        reset = 1'b0;
        @(negedge clock);

        // Header 0x0D: port 1, three payload bytes, correct parity 0x0D.
        e0 = errs[0];
        send_pkt(0, 8'h0D, 64'h332211, 3, 8'h00, 1'b1);
        drain(0, 1, 4 + PB);
        repeat (2) @(negedge clock);
        chk("good_pkt_err", errs[0] - e0, 0);

        // Same packet, parity byte corrupted to 0xFF: stored anyway, one err cycle.
        e0 = errs[0];
        send_pkt(0, 8'h0D, 64'h332211, 3, 8'hF2, 1'b1);
        drain(0, 1, 4 + PB);
        repeat (2) @(negedge clock);
        chk("bad_parity_err", errs[0] - e0, PB);

        // Header 0x03 addresses a nonexistent port: dropped with one err cycle.
        e0 = errs[0];
        send_pkt(0, 8'h03, 64'h0, 0, 8'h00, 1'b1);
        repeat (2) @(negedge clock);
        chk("bad_addr_vld", 32'(vld_v[0]), 0);
        chk("bad_addr_err", errs[0] - e0, 1);
        send_pkt(0, 8'h0E, 64'hC3B2A1, 3, 8'h00, 1'b1);
        drain(0, 2, 4 + PB);
        chk("after_drop_err", errs[0] - e0, 1);

        // Eight payload bytes into a 4-deep FIFO with reads delayed by 10 cycles.
        e1 = errs[1];
        fork
            send_pkt(1, 8'h20, 64'h0807060504030201, 8, 8'h00, 1'b1);
            begin
                repeat (9) @(negedge clock);
                chk("full_busy", 32'(busy_v[1]), 1);
                chk("full_vld", 32'(vld_v[1]), 1);
                @(negedge clock);
                drain(1, 0, 9 + PB);
            end
        join
        chk("full_err", errs[1] - e1, 0);

        // Port 2 loaded and never read: flushed 30 cycles after vld_out[2] rises.
        fork
            send_pkt(0, 8'h06, 64'h5A, 1, 8'h00, 1'b0);
            begin
                int k = 0;
                int n = 0;
                while (!vld_v[0][2] && k < 50) begin
                    @(negedge clock);
                    k++;
                end
                chk("timeout_vld_rise", 32'(vld_v[0][2]), 1);
                while (vld_v[0][2] && n < 100) begin
                    @(negedge clock);
                    n++;
                end
                chk("timeout_cycles", n, 30);
            end
        join

        // Reset in the middle of a payload, then a clean packet.
        put(0, 8'h0D, 1'b1);
        put(0, 8'h11, 1'b1);
        chk("pre_reset_vld", 32'(vld_v[0]), 3'b010);
        data_in = 8'h22;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        pv[0] = 1'b0;
        chk_idle(0, "midpkt_reset_dut0");
        chk_idle(1, "midpkt_reset_dut1");
        @(negedge clock);
        send_pkt(0, 8'h0D, 64'h332211, 3, 8'h00, 1'b1);
        drain(0, 1, 4 + PB);

        repeat (3) @(negedge clock);
        for (int q = 0; q < 6; q++) chk($sformatf("leftover_q%0d", q), exp_q[q].size(), 0);
        chk("total_err_dut0", errs[0], 1 + PB);
        chk("total_err_dut1", errs[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
